decoder_2x4_seq: RTL
====================

# decoder_2x4_seq

Sequenced 2-to-4 decoder: the receiving end of the 4x2 encoder's output code. It accepts 2-bit codes over a valid/ready handshake, buffers up to two codes, and drives each decoded one-hot word on `dout` for a fixed number of cycles before moving to the next. It sits downstream of the encoder and drives one-hot select lines that must be stable for a guaranteed minimum time.

## Interface
Parameters:
- `N_SEL`, default 2: code width. `dout` width is 2**N_SEL.
- `HOLD`, default 3: cycles each one-hot word is held. Legal range 1..255; out-of-range values are a compile-time error.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: decoder enable, active-high.
- `in_valid`, input, 1: `din` holds a code.
- `in_ready`, output, 1: the buffer can accept a code.
- `din`, input, N_SEL: code to decode.
- `dout`, output, 2**N_SEL: registered one-hot word; all zeros when not presenting.
- `dout_valid`, output, 1: `dout` holds a decoded word.
- `busy`, output, 1: the FSM is in HOLD or the buffer is non-empty.

## Operation
- Reset values:
  - `dout` = 0, `dout_valid` = 0, `busy` = 0, `in_ready` = 1.
  - FSM is in IDLE, hold counter = 0, buffer empty.
- Buffer:
  - 2-entry FIFO.
  - Push on `in_valid && in_ready`.
  - `in_ready` = !full, computed from registered state only. There is no bypass: a full buffer refuses a push even in a cycle where it also pops.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - If `en` && !empty: pop the head code c, then register `dout` = 1<<c, `dout_valid` = 1, counter = HOLD-1, and go to HOLD.
  - Otherwise stay in IDLE with `dout` = 0.
- HOLD:
  - If !`en`: abort. Next edge clears `dout` and `dout_valid` and returns to IDLE. Buffer contents are retained.
  - Else if counter != 0: decrement the counter and keep `dout`.
  - Else if !empty: pop the next code and load it back-to-back, with no idle gap and the counter reloaded.
  - Else: clear `dout` and `dout_valid` and go to IDLE.
- `en` does not gate `in_ready`. Codes may be buffered while disabled.
- One-hot invariant: when `dout_valid` = 1, `dout` has exactly one bit set; when `dout_valid` = 0, `dout` = 0.

## Timing
- Latency: a code pushed at edge k into an empty buffer while the FSM is in IDLE and `en` = 1 appears on `dout` after edge k+1.
- Each word is valid for exactly HOLD cycles. With HOLD = 1, back-to-back codes change `dout` every cycle.
- Throughput: one code per HOLD cycles while the buffer is non-empty.
- Push and pop in the same cycle on a non-full buffer: both occur and the count is unchanged.
- Pointer wrap: 1-bit read and write pointers wrap 1→0. Full/empty is derived from a 2-bit count.
- `rst` asserted mid-HOLD: the next edge forces all reset values. Buffered codes are discarded.
- `en` falling mid-HOLD: the remaining hold cycles are dropped and not resumed. The aborted word is not replayed.
- `en` rising while IDLE with a non-empty buffer: `dout` is updated at the next edge.

## Structure
- Package `decoder_pkg`:
  - `state_t` enum {IDLE, HOLD}.
  - Function `onehot(code)` returning 2**N_SEL bits.
  - Constant `CNT_W` = 8 for the hold counter.
- Sub-module `sync_fifo2`:
  - Parameterized width, 2 entries.
  - Ports `clk`, `rst`, `push`, `din`, `pop`, `dout`, `full`, `empty`.
  - Same reset convention as the top.
- Top: FSM, hold counter and output registers.

## Test plan
- Reset then idle: hold `rst` for 2 cycles → `dout` = 0000, `dout_valid` = 0, `in_ready` = 1, `busy` = 0.
- Single code, HOLD = 3, `en` = 1: push `din` = 2'b10 at edge k → `dout` = 0100 from edge k+1 through edge k+3, then 0000 after edge k+4.
- Back-to-back sweep: push 0,1,2,3 as fast as `in_ready` allows → `dout` shows 0001, 0010, 0100, 1000, each for 3 cycles with no gaps. `in_ready` = 0 while the buffer is full.
- Buffer full: `en` = 0, push 3 and 1 → `in_ready` = 0 after the 2nd push. A third `in_valid` is refused. Raise `en` → 1000, then 0010 is output.
- Abort: drop `en` on the 2nd cycle of holding 0010 → `dout` = 0000 at the next edge. The buffered next code is emitted after `en` returns.
- Reset mid-HOLD with 2 codes buffered → all outputs at reset values after the edge. No further output when `en` = 1.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 2-to-4 decoder.
// Hold counter width and the one-hot helper live here so sub-blocks agree on them.
package decoder_pkg;

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned OH_MAX = 2 ** CNT_W;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StHold = 1'b1
   } state_t;

   // Widest possible one-hot word; callers truncate to their own output width.
   function automatic logic [OH_MAX-1:0] onehot(input logic [CNT_W-1:0] code);
      logic [OH_MAX-1:0] word;
      word       = '0;
      word[code] = 1'b1;
      return word;
   endfunction

endpackage

// File: rtl/decoder_2x4_seq_fifo.sv
// Two-entry synchronous FIFO with 1-bit wrapping pointers and a 2-bit occupancy count.
// Pushes while full and pops while empty are ignored; there is no bypass path.
module sync_fifo2 #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wptr_q;
   logic             rptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= din;
            wptr_q        <= ~wptr_q;
         end
         if (do_pop) begin
            rptr_q <= ~rptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/decoder_2x4_seq.sv
// Sequenced decoder: buffers codes in a 2-entry FIFO and presents each as a one-hot
// word on dout for exactly HOLD cycles, back-to-back while codes are available.
module decoder_2x4_seq
   import decoder_pkg::*;
#(
   parameter int unsigned N_SEL = 2,
   parameter int unsigned HOLD  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_SEL-1:0]      din,
   output logic [2**N_SEL-1:0]   dout,
   output logic                  dout_valid,
   output logic                  busy
);

   localparam int unsigned OUT_W = 2 ** N_SEL;
   localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD - 1);

   if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
      $error("decoder_2x4_seq: HOLD must be in 1..255");
   end
   if (N_SEL < 1 || N_SEL > CNT_W) begin : g_bad_nsel
      $error("decoder_2x4_seq: N_SEL must be in 1..8");
   end

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OUT_W-1:0]   dout_q, dout_d;
   logic               valid_q, valid_d;
   logic [N_SEL-1:0]   head;
   logic               full;
   logic               empty;
   logic               pop;
   logic               load;

   sync_fifo2 #(
      .WIDTH (N_SEL)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && in_ready),
      .din   (din),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      load    = 1'b0;
      case (state_q)
         StIdle: begin
            if (en && !empty) begin
               load = 1'b1;
            end else begin
               dout_d  = '0;
               valid_d = 1'b0;
            end
         end
         StHold: begin
            // Disabling aborts the current word; the buffer is left untouched.
            if (!en) begin
               state_d = StIdle;
               dout_d  = '0;
               valid_d = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!empty) begin
               load = 1'b1;
            end else begin
               state_d = StIdle;
               dout_d  = '0;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            dout_d  = '0;
            valid_d = 1'b0;
         end
      endcase
      if (load) begin
         state_d = StHold;
         cnt_d   = HOLD_RELOAD;
         dout_d  = OUT_W'(onehot(CNT_W'(head)));
         valid_d = 1'b1;
      end
   end

   assign pop = load;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready   = !full;
   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = (state_q == StHold) || !empty;

endmodule
